sec_to_hms_bcd: RTL and testbench
=================================

Name: sec_to_hms_bcd

Overview:
- Converts a binary seconds-of-day count (0..86399) from the time-keeping counter into six BCD digits: HH MM SS.
- Sits between the time counter and the six-digit 7-segment scan driver.
- Uses sequential subtract-and-count, with no dividers.
- Conversion starts on a valid strobe; a one-cycle done pulse accompanies the new digits.

Parameters:
- DW, 17, width of the binary seconds input.
- MAX_SEC, 86_399, largest legal input value; anything above it is rejected.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-high: asserted = 1, sampled on the rising edge of clk.
- din  input  DW  binary seconds-of-day.
- din_vld  input  1  single-cycle strobe: din is valid this cycle.
- dout  output  24  BCD digits {h_tens, h_ones, m_tens, m_ones, s_tens, s_ones}, 4 bits each, MSB first.
- dout_vld  output  1  one-cycle pulse: dout has just been updated.
- busy  output  1  high while a conversion is in progress.
- err  output  1  one-cycle pulse: the input was rejected as out of range.

Behaviour:
- Reset (rst_n = 1 at an edge):
  - State goes to IDLE; dout = 24'h000000; dout_vld = busy = err = 0.
  - All internal working registers clear.
  - Reset overrides any conversion in progress; the partial result is discarded and dout stays 0.
- All outputs are registered.
- Internal registers: rem (DW bits); hrs and min (5 and 6 bits); sec (6 bits); h_t, m_t, s_t tens counters (3 bits each).
- IDLE:
  - din_vld = 1 and din <= MAX_SEC: rem <= din, hrs/min/tens <= 0, busy <= 1, go to HOUR.
  - din_vld = 1 and din > MAX_SEC: err <= 1 for one cycle, stay in IDLE, dout unchanged, busy stays 0.
- HOUR: if rem >= 3600, then rem <= rem - 3600 and hrs <= hrs + 1; otherwise go to MIN.
- MIN: if rem >= 60, then rem <= rem - 60 and min <= min + 1; otherwise sec <= rem[5:0] and go to SPLIT.
- SPLIT:
  - In parallel, each of hrs, min and sec that is >= 10 loses 10, and its tens counter increments.
  - When all three are < 10, go to DONE.
- DONE:
  - dout <= {h_t, hrs[3:0], m_t, min[3:0], s_t, sec[3:0]} (tens zero-extended to 4 bits).
  - dout_vld <= 1 for exactly one cycle; busy <= 0; return to IDLE.
- Latency:
  - Let H = hours, M = minutes, T = largest tens digit among the three fields.
  - din_vld sampled at edge 0 → dout_vld is high during the cycle after edge H+M+T+4.
  - Best case (din = 0): after edge 4. Worst case (din = 86399, 23:59:59): after edge 91.
- din_vld while busy = 1: ignored and dropped; no error, and the conversion in progress is unaffected.
- din_vld in the same cycle that DONE returns to IDLE: ignored, because the state is not yet IDLE. The sampling state is strictly IDLE.
- dout holds its last value between conversions; the scan driver may read it at any time.
- err and dout_vld are never high in the same cycle.
- No wrap-around inside the block: legal inputs cannot overflow hrs (max 23), min (max 59) or sec (max 59).

Test Plan:
- Reset → dout = 000000, dout_vld/busy/err = 0. Then din = 0 with din_vld → after edge 4, dout = 24'h000000 and dout_vld = 1 for one cycle.
- din = 45296 (12:34:56) → dout = 24'h123456; dout_vld exactly after edge 12+34+5+4 = 55; busy high from edge 1 through edge 55.
- din = 86399 → dout = 24'h235959, dout_vld after edge 91. din = 86400 → err pulses for one cycle, dout keeps 235959, busy stays 0.
- Start din = 3661 (01:01:01); pulse din_vld again with 59 at edge 2 → second strobe ignored; dout = 24'h010101; no further dout_vld.
- Start din = 86399; assert rst_n = 1 at edge 30 → the next cycle shows dout = 0, busy = 0 and no dout_vld. Then din = 59 → dout = 24'h000059.
- Feed strobes for 0, 1, ..., 120 back-to-back, each waiting for dout_vld → dout increments in BCD (000059 → 000100, 000159 → 000200) with no illegal nibble (> 9).

Source files
------------

// File: rtl/sec_to_hms_bcd.sv
// Purpose : binary seconds-of-day (0..MAX_SEC) to six BCD digits HH MM SS using subtract-and-count.
// Latency : din_vld at edge 0 -> dout_vld after edge H+M+T+4 (T = largest tens digit); 4..91 cycles.
// Backpr. : none; din_vld is taken only in IDLE, strobes while busy are dropped, out-of-range pulses err.
//
// Ports:
//   clk      - system clock
//   rst_n    - synchronous reset, active HIGH despite the name (1 = reset)
//   din      - binary seconds-of-day, sampled with din_vld
//   din_vld  - single-cycle input strobe
//   dout     - {h_tens, h_ones, m_tens, m_ones, s_tens, s_ones}, held between conversions
//   dout_vld - one-cycle pulse when dout has just been updated
//   busy     - high while a conversion is running
//   err      - one-cycle pulse when a strobed input exceeds MAX_SEC

module sec_to_hms_bcd #(
  parameter int DW      = 17,
  parameter int MAX_SEC = 86_399
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic [23:0]   dout,
  output logic          dout_vld,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    HOUR,
    MIN,
    SPLIT,
    DONE
  } state_t;

  localparam logic [DW-1:0] MAX_V   = DW'(MAX_SEC);
  localparam logic [DW-1:0] SEC_HR  = DW'(3600);
  localparam logic [DW-1:0] SEC_MIN = DW'(60);

  state_t        state;
  logic [DW-1:0] rem;
  logic [4:0]    hrs;
  logic [5:0]    min;
  logic [5:0]    sec;
  logic [2:0]    h_t;
  logic [2:0]    m_t;
  logic [2:0]    s_t;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      hrs      <= '0;
      min      <= '0;
      sec      <= '0;
      h_t      <= '0;
      m_t      <= '0;
      s_t      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Both pulses default low so each lasts exactly one cycle.
      dout_vld <= 1'b0;
      err      <= 1'b0;

      case (state)
        IDLE: begin
          if (din_vld) begin
            if (din <= MAX_V) begin
              rem   <= din;
              hrs   <= '0;
              min   <= '0;
              sec   <= '0;
              h_t   <= '0;
              m_t   <= '0;
              s_t   <= '0;
              busy  <= 1'b1;
              state <= HOUR;
            end else begin
              err <= 1'b1;
            end
          end
        end

        HOUR: begin
          if (rem >= SEC_HR) begin
            rem <= rem - SEC_HR;
            hrs <= hrs + 5'd1;
          end else begin
            state <= MIN;
          end
        end

        MIN: begin
          if (rem >= SEC_MIN) begin
            rem <= rem - SEC_MIN;
            min <= min + 6'd1;
          end else begin
            // Remainder is now < 60 and fits in six bits.
            sec   <= rem[5:0];
            state <= SPLIT;
          end
        end

        SPLIT: begin
          // All three fields peel off tens in parallel; the slowest field sets the duration.
          if (hrs >= 5'd10) begin
            hrs <= hrs - 5'd10;
            h_t <= h_t + 3'd1;
          end
          if (min >= 6'd10) begin
            min <= min - 6'd10;
            m_t <= m_t + 3'd1;
          end
          if (sec >= 6'd10) begin
            sec <= sec - 6'd10;
            s_t <= s_t + 3'd1;
          end
          if (hrs < 5'd10 && min < 6'd10 && sec < 6'd10) begin
            state <= DONE;
          end
        end

        DONE: begin
          dout     <= {1'b0, h_t, hrs[3:0], 1'b0, m_t, min[3:0], 1'b0, s_t, sec[3:0]};
          dout_vld <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sec_to_hms_bcd.sv
// Directed bench for sec_to_hms_bcd: reset state, conversions with latency/busy checks,
// range rejection, strobe-while-busy, reset mid-conversion, and a 0..120 BCD sweep.

module tb_sec_to_hms_bcd;

  logic        clk;
  logic        rst_n;
  logic [16:0] din;
  logic        din_vld;
  logic [23:0] dout;
  logic        dout_vld;
  logic        busy;
  logic        err;

  int tests;
  int fails;
  int cyc;
  int t0;

  sec_to_hms_bcd #(.DW(17), .MAX_SEC(86_399)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h (%0d), expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [23:0] bcd(input int h, input int m, input int s);
    logic [3:0] d5, d4, d3, d2, d1, d0;
    d5 = 4'(h / 10); d4 = 4'(h % 10);
    d3 = 4'(m / 10); d2 = 4'(m % 10);
    d1 = 4'(s / 10); d0 = 4'(s % 10);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int r;
    r = a;
    if (b > r) r = b;
    if (c > r) r = c;
    return r;
  endfunction

  // Drive one strobe; edge 0 is the edge that samples it, t0 marks it.
  task automatic strobe(input logic [16:0] v);
    @(negedge clk);
    din     = v;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    t0      = cyc;
  endtask

  // Wait for dout_vld (bounded), checking latency, busy through the run and one-cycle pulse.
  task automatic wait_done(input string tag, input int exp_lat, input logic [23:0] exp_dout);
    int  n;
    bit  seen;
    bit  busy_ok;
    bit  err_seen;
    n = 0; seen = 0; busy_ok = 1; err_seen = 0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (err) err_seen = 1;
      if (dout_vld) seen = 1;
      else if (!busy) busy_ok = 0;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(cyc - t0), 32'(exp_lat));
    chk({tag, " dout"}, 32'(dout), 32'(exp_dout));
    chk({tag, " busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, " busy_low_at_done"}, 32'(busy), 32'd0);
    chk({tag, " no_err"}, 32'(err_seen), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " vld_one_cycle"}, 32'(dout_vld), 32'd0);
  endtask

  initial begin
    int pulses;
    int m, s, lat;
    logic [23:0] e;
    bit nib_ok;

    tests = 0; fails = 0; cyc = 0; t0 = 0;
    rst_n = 1'b1; din = '0; din_vld = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst dout", 32'(dout), 32'h000000);
    chk("rst dout_vld", 32'(dout_vld), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // Best case: 0 -> 00:00:00 after edge 4
    strobe(17'd0);
    chk("zero busy_after_edge0", 32'(busy), 32'd1);
    wait_done("zero", 4, 24'h000000);

    // 45296 = 12:34:56, latency 12+34+5+4 = 55
    strobe(17'd45296);
    wait_done("123456", 55, 24'h123456);

    // Worst case 86399 = 23:59:59, latency 23+59+5+4 = 91
    strobe(17'd86399);
    wait_done("235959", 91, 24'h235959);

    // Out of range: err pulse, dout held, never busy
    strobe(17'd86400);
    chk("range err", 32'(err), 32'd1);
    chk("range busy", 32'(busy), 32'd0);
    chk("range dout_vld", 32'(dout_vld), 32'd0);
    chk("range dout_hold", 32'(dout), 32'h235959);
    @(posedge clk);
    #1;
    chk("range err_one_cycle", 32'(err), 32'd0);
    chk("range busy_stays_low", 32'(busy), 32'd0);

    // 3661 = 01:01:01 with a second strobe (59) at edge 2 that must be dropped
    strobe(17'd3661);
    @(posedge clk);            // edge 1
    @(negedge clk);
    din     = 17'd59;
    din_vld = 1'b1;
    @(posedge clk);            // edge 2
    #1;
    din_vld = 1'b0;
    chk("dbl err_on_busy_strobe", 32'(err), 32'd0);
    wait_done("dbl", 1 + 1 + 0 + 4, 24'h010101);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (dout_vld) pulses++;
    end
    chk("dbl no_extra_vld", 32'(pulses), 32'd0);
    chk("dbl dout_hold", 32'(dout), 32'h010101);

    // Reset at edge 30 of an 86399 conversion
    strobe(17'd86399);
    while (cyc - t0 < 29) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);            // edge 30
    #1;
    rst_n = 1'b0;
    chk("midrst dout", 32'(dout), 32'h000000);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst dout_vld", 32'(dout_vld), 32'd0);
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (dout_vld) pulses++;
    end
    chk("midrst no_late_vld", 32'(pulses), 32'd0);
    chk("midrst dout_still_zero", 32'(dout), 32'h000000);
    strobe(17'd59);
    wait_done("after_rst 59", 0 + 0 + 5 + 4, 24'h000059);

    // Back-to-back sweep 0..120: BCD carries and digit legality
    for (int i = 0; i <= 120; i++) begin
      m   = i / 60;
      s   = i % 60;
      e   = bcd(0, m, s);
      lat = m + max3(0, m / 10, s / 10) + 4;
      strobe(17'(i));
      wait_done($sformatf("sweep %0d", i), lat, e);
      nib_ok = 1;
      for (int k = 0; k < 6; k++) begin
        if (dout[k*4 +: 4] > 4'd9) nib_ok = 0;
      end
      chk($sformatf("sweep %0d nibbles", i), 32'(nib_ok), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
